fifo_uart_tx: RTL and testbench

Drain-side reader for the team's synchronous FIFO. It watches the FIFO empty flag, issues single-cycle read strobes, and captures the word returned one cycle later. It then serialises each word onto an asynchronous UART line: start bit, data LSB-first, optional parity, then stop bit(s). It sits between the FIFO's read port and the chip-level txd pin.

---
 rtl/fifo_uart_pkg.sv | 30 +++
 rtl/fifo_uart_tx_bit_timer.sv | 38 +++
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state encoding, frame sizing and parity helper for fifo_uart_tx.
// Rev 1.0
`default_nettype none

package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  localparam int START_BITS = 1;

  function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
    return START_BITS + data_width + parity_en + stop_bits;
  endfunction

  // Even parity is the plain XOR reduction; odd parity inverts it.
  function automatic logic parity_of(input logic [63:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_bit_timer.sv
// uart_bit_timer: bit-period counter; bit_tick marks the last clk of each bit, near_tick the one before.
// Rev 1.0
`default_nettype none

module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_tick,
  output logic near_tick
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] NEAR_CNT = CNT_WIDTH'(CLKS_PER_BIT - 2);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick  = run && (cnt == LAST_CNT);
  assign near_tick = run && (cnt == NEAR_CNT);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and serialises them as UART frames on txd.
// Rev 1.0
`default_nettype none

module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FRAME_BITS = frame_bits(DATA_WIDTH, PARITY_EN, STOP_BITS);
  localparam int FB_W       = $clog2(FRAME_BITS);
  localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [FB_W-1:0]  LAST_FRAME_BIT = FB_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             ODD            = (PARITY_ODD != 0);

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic                  parity_bit;
  logic [IDX_W-1:0]      bit_idx;
  logic [FB_W-1:0]       frame_bit;
  logic                  run;
  logic                  bit_tick;
  logic                  near_tick;

  assign run = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .bit_tick (bit_tick),
    .near_tick(near_tick)
  );

  // txd is loaded one edge ahead of each bit so the line stays fully registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      txd        <= 1'b1;
      fifo_read  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      parity_bit <= 1'b0;
      bit_idx    <= '0;
      frame_bit  <= '0;
    end else begin
      fifo_read  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && !fifo_empty) begin
            state     <= ST_FETCH;
            fifo_read <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          shift      <= fifo_data;
          parity_bit <= parity_of(64'(fifo_data), ODD);
          bit_idx    <= '0;
          frame_bit  <= '0;
          txd        <= 1'b0;
          state      <= ST_START;
        end
        ST_START: begin
          if (bit_tick) begin
            state     <= ST_DATA;
            txd       <= shift[0];
            shift     <= shift >> 1;
            frame_bit <= frame_bit + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            frame_bit <= frame_bit + 1'b1;
            if (bit_idx == LAST_DATA_IDX) begin
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                txd   <= parity_bit;
              end else begin
                state <= ST_STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            state     <= ST_STOP;
            txd       <= 1'b1;
            frame_bit <= frame_bit + 1'b1;
          end
        end
        ST_STOP: begin
          if (near_tick && frame_bit == LAST_FRAME_BIT) begin
            frame_done <= 1'b1;
          end
          if (bit_tick) begin
            if (frame_bit == LAST_FRAME_BIT) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_bit <= '0;
            end else begin
              frame_bit <= frame_bit + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx framing, latency, parity, enable and reset behaviour.
// Rev 1.0
`default_nettype none

module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_read;
  logic [7:0] fifo_data;
  logic       txd;
  logic       busy;
  logic       frame_done;

  logic       p_empty;
  logic [7:0] p_data;
  logic       pe_read, pe_txd, pe_busy, pe_done;
  logic       po_read, po_txd, po_busy, po_done;

  logic [7:0] words [0:7];
  int         rd_ptr;
  int         vectors;
  int         errs;

  always #5 clk = ~clk;

  assign p_data = 8'h07;

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .CNT_WIDTH(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .fifo_data(fifo_data), .txd(txd), .busy(busy),
    .frame_done(frame_done)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .CNT_WIDTH(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_even (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(p_empty),
    .fifo_read(pe_read), .fifo_data(p_data), .txd(pe_txd), .busy(pe_busy),
    .frame_done(pe_done)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .CNT_WIDTH(8),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) dut_odd (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(p_empty),
    .fifo_read(po_read), .fifo_data(p_data), .txd(po_txd), .busy(po_busy),
    .frame_done(po_done)
  );

  // FIFO read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_data <= words[rd_ptr[2:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Expected line level at offset rel from the first start-bit cycle (4 clks per bit).
  function automatic logic m_txd(input int rel, input logic [7:0] w, input int np, input logic pb);
    int idx;
    if (rel < 0) return 1'b1;
    if (rel < 4) return 1'b0;
    if (rel < 36) begin
      idx = (rel - 4) / 4;
      return w[idx[2:0]];
    end
    if (np == 1 && rel < 40) return pb;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s @cyc %0d: observed %0b expected %0b", tag, c, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input int c, input int s, input logic [7:0] w,
                           input int np, input int ns, input logic pb,
                           input logic o_txd, input logic o_read, input logic o_busy,
                           input logic o_done);
    int rel;
    int len;
    rel = c - s;
    len = (9 + np + ns) * 4;
    chk({nm, ".txd"}, c, o_txd, m_txd(rel, w, np, pb));
    chk({nm, ".fifo_read"}, c, o_read, rel == -2);
    chk({nm, ".busy"}, c, o_busy, (rel >= -2) && (rel < len));
    chk({nm, ".frame_done"}, c, o_done, rel == len - 1);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    vectors    = 0;
    errs       = 0;
    rd_ptr     = 0;
    fifo_data  = 8'h00;
    words[0] = 8'hA5; words[1] = 8'h00; words[2] = 8'hFF; words[3] = 8'hA5;
    words[4] = 8'h3C; words[5] = 8'h5A; words[6] = 8'h00; words[7] = 8'h00;
    reset      = 1'b1;
    enable     = 1'b1;
    fifo_empty = 1'b0;
    p_empty    = 1'b1;

    // Reset held with a non-empty FIFO: no read, idle outputs.
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check_dut("rst", c, 1000, 8'h00, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
    end
    reset      = 1'b0;
    fifo_empty = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check_dut("idle", c, 1000, 8'h00, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
    end
    chk_int("reads_after_reset", rd_ptr, 0);

    // Single 0xA5 frame.
    fifo_empty = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      check_dut("a5", c, 3, 8'hA5, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
      if (c == 1) fifo_empty = 1'b1;
    end
    chk_int("reads_single", rd_ptr, 1);

    // Back-to-back 0x00 then 0xFF.
    fifo_empty = 1'b0;
    for (int c = 1; c <= 88; c++) begin
      @(negedge clk);
      if (c <= 42)
        check_dut("b2b0", c, 3, 8'h00, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
      else
        check_dut("b2b1", c, 46, 8'hFF, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
      if (c == 44) fifo_empty = 1'b1;
    end
    chk_int("reads_b2b", rd_ptr, 3);

    // enable dropped mid-frame with the FIFO still holding a word.
    fifo_empty = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      check_dut("endrop", c, 3, 8'hA5, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
      if (c == 10) enable = 1'b0;
    end
    chk_int("reads_endrop", rd_ptr, 4);

    // Reset during the 0x3C frame; 0x5A is then sent with normal latency.
    enable = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c <= 20)
        check_dut("pre_rst", c, 3, 8'h3C, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
      else
        check_dut("in_rst", c, 1000, 8'h00, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
      if (c == 20) reset = 1'b1;
    end
    reset = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      check_dut("post_rst", c, 3, 8'h5A, 0, 1, 1'b0, txd, fifo_read, busy, frame_done);
      if (c == 1) fifo_empty = 1'b1;
    end
    chk_int("reads_post_rst", rd_ptr, 6);

    // 0x07 with even parity (bit 1, 1 stop) and odd parity (bit 0, 2 stops).
    p_empty = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      check_dut("even", c, 3, 8'h07, 1, 1, 1'b1, pe_txd, pe_read, pe_busy, pe_done);
      check_dut("odd", c, 3, 8'h07, 1, 2, 1'b0, po_txd, po_read, po_busy, po_done);
      if (c == 1) p_empty = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire
